// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps all N_IN-bit vectors into a gate and checks its output against reduction-AND.
// Optional comparator and error capture compiled in with `define TTSEQ_CHECK_EN.
module truth_table_sequencer #(
    parameter int N_IN = 2,
    parameter int HOLD = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    output logic [N_IN-1:0] o_vec,
    input  logic            i_dut_out,
    output logic            o_busy,
    output logic            o_done,
    output logic [N_IN:0]   o_err_cnt,
    output logic [N_IN-1:0] o_first_err_vec,
    output logic            o_pass
);
    localparam int HW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N_IN:0]   err_q, err_d, err_n;
    logic [N_IN-1:0] first_q, first_d, first_n;
    logic            pass_q, pass_d, pass_n;
    logic            last;

    assign last = hold_q == HW'(HOLD - 1);

`ifdef TTSEQ_CHECK_EN
    logic miss;
    assign miss    = state_q == RUN && last && (i_dut_out != &vec_q);
    assign err_n   = miss ? err_q + 1'b1 : err_q;
    assign first_n = (miss && err_q == '0) ? vec_q : first_q;
    assign pass_n  = err_n == '0;
`else
    logic unused_dut;
    assign unused_dut = i_dut_out;
    assign err_n      = '0;
    assign first_n    = '0;
    assign pass_n     = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: if (i_start) begin
                state_d = RUN;
                vec_d   = '0;
                hold_d  = '0;
                busy_d  = 1'b1;
                err_d   = '0;
                first_d = '0;
                pass_d  = 1'b0;
            end
            RUN: begin
                err_d   = err_n;
                first_d = first_n;
                if (!last) begin
                    hold_d = hold_q + 1'b1;
                end else if (&vec_q) begin
                    // vec returns to 0 here so o_vec reads 0 in DONE
                    state_d = DONE;
                    vec_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = pass_n;
                end else begin
                    vec_d  = vec_q + 1'b1;
                    hold_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    assign o_vec           = vec_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_err_cnt       = err_q;
    assign o_first_err_vec = first_q;
    assign o_pass          = pass_q;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: directed checks of a 2-input/HOLD=2 and a 3-input/HOLD=1 sequencer.
module tb_truth_table_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start2 = 1'b0, start3 = 1'b0, use_or = 1'b0;
    logic [1:0] vec2, first2;
    logic [2:0] err2, vec3, first3;
    logic [3:0] err3;
    logic       busy2, done2, pass2, busy3, done3, pass3;
    logic       gate2, gate3;
    int         checks = 0, errors = 0, pulses;

    always #5 clk = ~clk;

    assign gate2 = use_or ? |vec2 : &vec2;
    assign gate3 = &vec3;

    truth_table_sequencer #(.N_IN(2), .HOLD(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .o_vec(vec2), .i_dut_out(gate2),
        .o_busy(busy2), .o_done(done2), .o_err_cnt(err2), .o_first_err_vec(first2), .o_pass(pass2)
    );

    truth_table_sequencer #(.N_IN(3), .HOLD(1)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .o_vec(vec3), .i_dut_out(gate3),
        .o_busy(busy3), .o_done(done3), .o_err_cnt(err3), .o_first_err_vec(first3), .o_pass(pass3)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Pulse start at a negedge; returns in cycle S+1, then checks the 8 RUN cycles and DONE.
    task automatic sweep2(input logic [2:0] e_err, input logic [1:0] e_first, input logic e_pass);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("run_vec", vec2, k / 2);
            chk("run_busy", busy2, 1);
            chk("run_done", done2, 0);
            @(negedge clk);
        end
        chk("done_pulse", done2, 1);
        chk("done_busy", busy2, 0);
        chk("done_vec", vec2, 0);
        chk("err_cnt", err2, e_err);
        chk("first_err", first2, e_first);
        chk("pass", pass2, e_pass);
        @(negedge clk);
        chk("done_low", done2, 0);
        chk("pass_hold", pass2, e_pass);
        chk("err_hold", err2, e_err);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_vec", vec2, 0);
        chk("rst_busy", busy2, 0);
        chk("rst_done", done2, 0);
        chk("rst_err", err2, 0);
        chk("rst_pass", pass2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        sweep2(3'd0, 2'd0, 1'b1);
        use_or = 1'b1;
`ifdef TTSEQ_CHECK_EN
        sweep2(3'd2, 2'd1, 1'b0);
`else
        sweep2(3'd0, 2'd0, 1'b1);
`endif
        use_or = 1'b0;

        // start held high: single sweep, restart only after DONE
        start2 = 1'b1;
        pulses = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (done2) pulses++;
        end
        chk("held_pulses", pulses, 1);
        chk("held_done_now", done2, 1);
        @(negedge clk);
        chk("held_idle_busy", busy2, 0);
        @(negedge clk);
        chk("held_restart_busy", busy2, 1);
        chk("held_restart_vec", vec2, 0);
        start2 = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done2) pulses++;
        end
        chk("held_second_done", pulses, 1);

        // reset mid-sweep while vec=10
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_vec", vec2, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_vec", vec2, 0);
        chk("abort_busy", busy2, 0);
        chk("abort_done", done2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done2 || busy2) pulses++;
        end
        chk("no_done_after_abort", pulses, 0);
        sweep2(3'd0, 2'd0, 1'b1);

        // N_IN=3, HOLD=1
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("n3_vec", vec3, k);
            chk("n3_busy", busy3, 1);
            @(negedge clk);
        end
        chk("n3_done", done3, 1);
        chk("n3_err", err3, 0);
        chk("n3_pass", pass3, 1);
        chk("n3_first", first3, 0);
        @(negedge clk);
        chk("n3_done_low", done3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
